run_ctrl: RTL
=============

RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 Parameter PC_W, default 10, width of the program counter load value.
REQ-002 Parameter CNT_W, default 32, width of the run-cycle counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 n_reset  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 net_valid_i  input  1  network command valid.
REQ-006 net_cmd_i  input  2  command: 00 NOP, 01 WRITE_PC, 10 START, 11 HALT.
REQ-007 net_data_i  input  16  command payload; low PC_W bits = PC for WRITE_PC.
REQ-008 net_ready_o  output  1  controller can accept a command this cycle.
REQ-009 wait_i  input  1  decoded WAIT instruction in execute stage.
REQ-010 exception_i  input  1  core exception raised this cycle.
REQ-011 stall_i  input  1  pipeline stalled this cycle.
REQ-012 state_o  output  2  registered state: 00 IDLE, 01 RUN, 10 DRAIN, 11 ERR.
REQ-013 pc_wen_o  output  1  one-cycle PC load strobe.
REQ-014 pc_o  output  PC_W  PC load value, valid when pc_wen_o=1.
REQ-015 cmd_drop_o  output  1  one-cycle pulse: accepted command illegal in current state, discarded.
REQ-016 run_cycles_o  output  CNT_W  count of unstalled RUN cycles.

Function
REQ-017 A command SHALL be accepted only on a cycle with net_valid_i=1 and net_ready_o=1; NOP is accepted with no effect.
REQ-018 net_ready_o SHALL be combinational: 0 in DRAIN, 1 in IDLE, RUN, ERR.
REQ-019 WRITE_PC accepted in IDLE SHALL register pc_o <= net_data_i[PC_W-1:0] and assert pc_wen_o for exactly the following cycle.
REQ-020 START accepted in IDLE SHALL move to RUN next cycle and clear run_cycles_o to 0 in that same edge.
REQ-021 HALT accepted in RUN SHALL move to IDLE next cycle if stall_i=0, else to DRAIN.
REQ-022 DRAIN SHALL remain until the first cycle with stall_i=0, then move to IDLE (or ERR per REQ-024).
REQ-023 wait_i=1 with stall_i=0 in RUN SHALL move to IDLE next cycle; wait_i is ignored in other states or while stall_i=1.
REQ-024 exception_i=1 with stall_i=0 in RUN or DRAIN SHALL move to ERR next cycle; ignored in IDLE and ERR.
REQ-025 Same-cycle priority in RUN: exception > HALT > wait_i.
REQ-026 ERR SHALL persist until an accepted HALT, which moves to IDLE next cycle.
REQ-027 WRITE_PC or START accepted outside IDLE, and HALT accepted in IDLE, SHALL be discarded and pulse cmd_drop_o for the following cycle; state and pc_o unchanged.
REQ-028 run_cycles_o SHALL increment by 1 on each cycle in RUN with stall_i=0 and saturate at 2^CNT_W-1 (no wrap).
REQ-029 run_cycles_o SHALL hold its value in IDLE, DRAIN, ERR, and on stalled RUN cycles.
REQ-030 pc_wen_o and cmd_drop_o SHALL be registered single-cycle pulses, never asserted two consecutive cycles for one command.

Reset
REQ-031 n_reset=0 at a rising edge SHALL force state_o=IDLE, pc_o=0, pc_wen_o=0, cmd_drop_o=0, run_cycles_o=0, overriding any same-cycle command or event.
REQ-032 Reset asserted mid-RUN or mid-DRAIN SHALL take effect at that edge; first post-reset cycle accepts commands (net_ready_o=1).

Verification
REQ-033 Reset, WRITE_PC data=0x0123 (PC_W=10), START -> pc_wen_o=1 one cycle with pc_o=0x123; state_o=RUN the cycle after START; run_cycles_o counts 1,2,3...
REQ-034 RUN, stall_i=1 for 3 cycles, HALT accepted in first stalled cycle -> state DRAIN, net_ready_o=0 for 3 cycles, then IDLE; run_cycles_o unchanged during stall.
REQ-035 RUN, same cycle exception_i=1, HALT valid, wait_i=1, stall_i=0 -> state ERR; then HALT -> IDLE.
REQ-036 START accepted in RUN, WRITE_PC in ERR, HALT in IDLE -> each gives one-cycle cmd_drop_o, no state/pc_o change.
REQ-037 CNT_W=4, 20 unstalled RUN cycles -> run_cycles_o saturates at 15; next START resets it to 0.
REQ-038 n_reset=0 during DRAIN with stall_i=1 -> state_o=IDLE, all outputs at reset values next cycle.

Source files
------------

// File: rtl/run_ctrl.sv
// Run/halt controller for a core: accepts network commands, tracks IDLE/RUN/DRAIN/ERR,
// issues PC load strobes and counts unstalled run cycles.
module run_ctrl #(
  parameter int unsigned PC_W  = 10,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             net_valid_i,
  input  logic [1:0]       net_cmd_i,
  input  logic [15:0]      net_data_i,
  output logic             net_ready_o,
  input  logic             wait_i,
  input  logic             exception_i,
  input  logic             stall_i,
  output logic [1:0]       state_o,
  output logic             pc_wen_o,
  output logic [PC_W-1:0]  pc_o,
  output logic             cmd_drop_o,
  output logic [CNT_W-1:0] run_cycles_o
);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StDrain = 2'b10,
    StErr   = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    CmdNop     = 2'b00,
    CmdWritePc = 2'b01,
    CmdStart   = 2'b10,
    CmdHalt    = 2'b11
  } cmd_e;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             pc_wen_q, pc_wen_d;
  logic             cmd_drop_q, cmd_drop_d;
  logic [CNT_W-1:0] run_cycles_q, run_cycles_d;

  logic accept;
  logic is_write_pc, is_start, is_halt;
  logic cnt_sat;

  // Upper payload bits beyond the PC width carry no meaning here.
  logic unused_data;
  assign unused_data = ^net_data_i;

  assign net_ready_o = (state_q != StDrain);
  assign accept      = net_valid_i & net_ready_o;
  assign is_write_pc = accept & (cmd_e'(net_cmd_i) == CmdWritePc);
  assign is_start    = accept & (cmd_e'(net_cmd_i) == CmdStart);
  assign is_halt     = accept & (cmd_e'(net_cmd_i) == CmdHalt);
  assign cnt_sat     = (run_cycles_q == {CNT_W{1'b1}});

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pc_wen_d     = 1'b0;
    cmd_drop_d   = 1'b0;
    run_cycles_d = run_cycles_q;

    unique case (state_q)
      StIdle: begin
        if (is_write_pc) begin
          pc_d     = net_data_i[PC_W-1:0];
          pc_wen_d = 1'b1;
        end else if (is_start) begin
          state_d      = StRun;
          run_cycles_d = '0;
        end else if (is_halt) begin
          cmd_drop_d = 1'b1;
        end
      end

      StRun: begin
        if (!stall_i && !cnt_sat) begin
          run_cycles_d = run_cycles_q + CNT_W'(1);
        end
        // Priority: exception, then HALT, then WAIT.
        if (exception_i && !stall_i) begin
          state_d = StErr;
        end else if (is_halt) begin
          state_d = stall_i ? StDrain : StIdle;
        end else if (wait_i && !stall_i) begin
          state_d = StIdle;
        end
        if (is_write_pc || is_start) begin
          cmd_drop_d = 1'b1;
        end
      end

      StDrain: begin
        // Not ready here, so no command can be accepted.
        if (!stall_i) begin
          state_d = exception_i ? StErr : StIdle;
        end
      end

      StErr: begin
        if (is_halt) begin
          state_d = StIdle;
        end else if (is_write_pc || is_start) begin
          cmd_drop_d = 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q      <= StIdle;
      pc_q         <= '0;
      pc_wen_q     <= 1'b0;
      cmd_drop_q   <= 1'b0;
      run_cycles_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pc_wen_q     <= pc_wen_d;
      cmd_drop_q   <= cmd_drop_d;
      run_cycles_q <= run_cycles_d;
    end
  end

  assign state_o      = state_q;
  assign pc_o         = pc_q;
  assign pc_wen_o     = pc_wen_q;
  assign cmd_drop_o   = cmd_drop_q;
  assign run_cycles_o = run_cycles_q;

endmodule
